// File: rtl/oqpsk_pkg.sv
// Shared definitions for the OQPSK transmit path: sequencer state encoding and
// the pacing defaults that the modulator is built against.
package oqpsk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    localparam int SPS_DEF   = 32;
    localparam int TAIL_DEF  = 64;
    localparam int DIV_W_DEF = 8;

endpackage

// File: rtl/oqpsk_sample_div.sv
// Programmable sample-request divider: one REQ pulse every (div+1) enabled
// clocks, starting from a cleared count.
module oqpsk_sample_div
    import oqpsk_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             req
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        req   = en && (cnt_q == div);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = req ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oqpsk_tx_sequencer.sv
// Feeds the OQPSK modulator: accepts words over valid/ready, serializes them
// MSB-first at SPS sample requests per bit, then drains the filter with zeros.
module oqpsk_tx_sequencer
    import oqpsk_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int SPS    = SPS_DEF,
    parameter int TAIL   = TAIL_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              ACK,
    input  logic              RST,
    input  logic              START,
    input  logic [DIV_W-1:0]  DIV,
    input  logic [WORD_W-1:0] WORD_DATA,
    input  logic              WORD_LAST,
    input  logic              WORD_VALID,
    output logic              WORD_READY,
    output logic              REQ_SAMPLE,
    output logic              EN,
    output logic              BIT_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              UNDERRUN
);

    localparam int SCNT_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int TCNT_W = (TAIL > 1) ? $clog2(TAIL) : 1;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                hold_last_q, hold_last_d;
    logic                cur_last_q, cur_last_d;
    logic                last_seen_q, last_seen_d;
    logic [SCNT_W-1:0]   samp_q, samp_d;
    logic [BCNT_W-1:0]   bit_q, bit_d;
    logic [TCNT_W-1:0]   tail_q, tail_d;
    logic                underrun_q, underrun_d;
    logic                done_q, done_d;

    logic                div_en;
    logic                req;
    logic                accept;
    logic                bit_adv;
    logic                word_end;

    assign div_en = (state_q == RUN) || (state_q == FLUSH);

    oqpsk_sample_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk (ACK),
        .rst (RST),
        .clr (!div_en),
        .en  (div_en),
        .div (div_q),
        .req (req)
    );

    assign WORD_READY = (state_q == PRIME) ||
                        ((state_q == RUN) && !hold_full_q && !last_seen_q);
    assign accept     = WORD_VALID && WORD_READY;
    assign bit_adv    = req && (samp_q == SCNT_W'(SPS - 1));
    assign word_end   = bit_adv && (bit_q == BCNT_W'(WORD_W - 1));

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        hold_last_d = hold_last_q;
        cur_last_d  = cur_last_q;
        last_seen_d = last_seen_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        tail_d      = tail_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d     = PRIME;
                    div_d       = DIV;
                    underrun_d  = 1'b0;
                    hold_full_d = 1'b0;
                    hold_last_d = 1'b0;
                    cur_last_d  = 1'b0;
                    last_seen_d = 1'b0;
                    samp_d      = '0;
                    bit_d       = '0;
                    tail_d      = '0;
                end
            end
            PRIME: begin
                if (accept) begin
                    sh_d        = WORD_DATA;
                    cur_last_d  = WORD_LAST;
                    last_seen_d = WORD_LAST;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    hold_d      = WORD_DATA;
                    hold_last_d = WORD_LAST;
                    hold_full_d = 1'b1;
                    last_seen_d = last_seen_q | WORD_LAST;
                end
                if (req) begin
                    samp_d = bit_adv ? '0 : samp_q + 1'b1;
                end
                if (bit_adv) begin
                    bit_d = word_end ? '0 : bit_q + 1'b1;
                    sh_d  = sh_q << 1;
                end
                if (word_end) begin
                    if (hold_full_q) begin
                        sh_d        = hold_q;
                        cur_last_d  = hold_last_q;
                        hold_full_d = accept;
                    end else if (accept) begin
                        // Word arriving on the boundary edge goes straight to the shifter.
                        sh_d        = WORD_DATA;
                        cur_last_d  = WORD_LAST;
                        hold_full_d = 1'b0;
                    end else if (cur_last_q) begin
                        state_d = FLUSH;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (req) begin
                    if (tail_q == TCNT_W'(TAIL - 1)) begin
                        tail_d  = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        tail_d = tail_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            div_q       <= '0;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            cur_last_q  <= 1'b0;
            last_seen_q <= 1'b0;
            samp_q      <= '0;
            bit_q       <= '0;
            tail_q      <= '0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            hold_last_q <= hold_last_d;
            cur_last_q  <= cur_last_d;
            last_seen_q <= last_seen_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            tail_q      <= tail_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
        end
    end

    assign REQ_SAMPLE = req;
    assign EN         = div_en;
    assign BIT_OUT    = (state_q == RUN) && sh_q[WORD_W-1];
    assign BUSY       = (state_q != IDLE);
    assign DONE       = done_q;
    assign UNDERRUN   = underrun_q;

endmodule

// File: tb/tb_oqpsk_tx_sequencer.sv
// Directed bench for oqpsk_tx_sequencer with WORD_W=8, SPS=4, TAIL=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_oqpsk_tx_sequencer;

    localparam int WORD_W = 8;
    localparam int SPS    = 4;
    localparam int TAIL   = 8;
    localparam int DIV_W  = 8;

    logic              ACK = 1'b0;
    logic              RST;
    logic              START;
    logic [DIV_W-1:0]  DIV;
    logic [WORD_W-1:0] WORD_DATA;
    logic              WORD_LAST;
    logic              WORD_VALID;
    logic              WORD_READY;
    logic              REQ_SAMPLE;
    logic              EN;
    logic              BIT_OUT;
    logic              BUSY;
    logic              DONE;
    logic              UNDERRUN;

    int n_tests = 0;
    int n_fail  = 0;

    oqpsk_tx_sequencer #(
        .WORD_W (WORD_W),
        .SPS    (SPS),
        .TAIL   (TAIL),
        .DIV_W  (DIV_W)
    ) dut (
        .ACK        (ACK),
        .RST        (RST),
        .START      (START),
        .DIV        (DIV),
        .WORD_DATA  (WORD_DATA),
        .WORD_LAST  (WORD_LAST),
        .WORD_VALID (WORD_VALID),
        .WORD_READY (WORD_READY),
        .REQ_SAMPLE (REQ_SAMPLE),
        .EN         (EN),
        .BIT_OUT    (BIT_OUT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .UNDERRUN   (UNDERRUN)
    );

    always #5 ACK = ~ACK;

    task automatic tick();
        @(negedge ACK);
    endtask

    // Stimulus only: START with a divider, then one word through PRIME.
    // Returns in the first RUN cycle.
    task automatic start_frame(input logic [DIV_W-1:0] d, input logic [WORD_W-1:0] w,
                               input logic last);
        START = 1'b1; DIV = d;
        tick();
        START = 1'b0;
        WORD_DATA = w; WORD_LAST = last; WORD_VALID = 1'b1;
        tick();
        WORD_VALID = 1'b0; WORD_LAST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; DIV = '0;
        WORD_DATA = '0; WORD_LAST = 1'b0; WORD_VALID = 1'b0;
        tick(); tick();
        n_tests++;
        if ({WORD_READY, REQ_SAMPLE, EN, BIT_OUT, BUSY, DONE, UNDERRUN} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy/req/en/bit/busy/done/und=%b want 0000000",
                     {WORD_READY, REQ_SAMPLE, EN, BIT_OUT, BUSY, DONE, UNDERRUN});
        end
        RST = 1'b0;
        WORD_VALID = 1'b1; WORD_DATA = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (WORD_READY !== 1'b0 || BUSY !== 1'b0 || EN !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_accept c=%0d got rdy=%b busy=%b en=%b want 0 0 0",
                         c, WORD_READY, BUSY, EN);
            end
        end
        WORD_VALID = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] w;
        logic eb;
        w = 8'hA5;
        START = 1'b1; DIV = 8'd0;
        tick();
        START = 1'b0;
        n_tests++;
        if (BUSY !== 1'b1 || WORD_READY !== 1'b1 || EN !== 1'b0) begin
            n_fail++;
            $display("FAIL single_prime got busy=%b rdy=%b en=%b want 1 1 0", BUSY, WORD_READY, EN);
        end
        WORD_DATA = w; WORD_LAST = 1'b1; WORD_VALID = 1'b1;
        tick();
        WORD_VALID = 1'b0; WORD_LAST = 1'b0;
        for (int c = 0; c < 40; c++) begin
            eb = (c < 32) ? w[7 - c / 4] : 1'b0;
            n_tests++;
            if (EN !== 1'b1 || BIT_OUT !== eb || REQ_SAMPLE !== 1'b1 || DONE !== 1'b0 ||
                BUSY !== 1'b1 || UNDERRUN !== 1'b0) begin
                n_fail++;
                $display("FAIL single_run c=%0d got en=%b bit=%b req=%b done=%b busy=%b und=%b want 1 %b 1 0 1 0",
                         c, EN, BIT_OUT, REQ_SAMPLE, DONE, BUSY, UNDERRUN, eb);
            end
            tick();
        end
        n_tests++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || EN !== 1'b0 || UNDERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done got done=%b busy=%b en=%b und=%b want 1 0 0 0",
                     DONE, BUSY, EN, UNDERRUN);
        end
        tick();
        n_tests++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_pulse got done=%b want 0", DONE);
        end
    endtask

    task automatic test_divider();
        logic eb, er;
        start_frame(8'd3, 8'hFF, 1'b1);
        for (int c = 0; c < 160; c++) begin
            eb = (c < 128);
            er = ((c % 4) == 3);
            n_tests++;
            if (EN !== 1'b1 || BIT_OUT !== eb || REQ_SAMPLE !== er || DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL div_run c=%0d got en=%b bit=%b req=%b done=%b want 1 %b %b 0",
                         c, EN, BIT_OUT, REQ_SAMPLE, DONE, eb, er);
            end
            tick();
        end
        n_tests++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || REQ_SAMPLE !== 1'b0) begin
            n_fail++;
            $display("FAIL div_done got done=%b busy=%b req=%b want 1 0 0", DONE, BUSY, REQ_SAMPLE);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [7:0] wd;
        logic eb, er, acc;
        int idx, n_acc;
        words = '{8'h80, 8'h01, 8'hC3};
        idx = 0; n_acc = 0;
        START = 1'b1; DIV = 8'd0;
        tick();
        START = 1'b0;
        WORD_DATA = words[0]; WORD_LAST = 1'b0; WORD_VALID = 1'b1;
        for (int c = -1; c <= 104; c++) begin
            if (c == -1) begin
                n_tests++;
                if (WORD_READY !== 1'b1 || BUSY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_prime got rdy=%b busy=%b want 1 1", WORD_READY, BUSY);
                end
            end else if (c < 104) begin
                wd = words[(c < 96) ? c / 32 : 2];
                eb = (c < 96) ? wd[7 - (c % 32) / 4] : 1'b0;
                er = (c == 0) || (c == 32);
                n_tests++;
                if (BIT_OUT !== eb || WORD_READY !== er || EN !== 1'b1 || DONE !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_run c=%0d got bit=%b rdy=%b en=%b done=%b want %b %b 1 0",
                             c, BIT_OUT, WORD_READY, EN, DONE, eb, er);
                end
            end else begin
                n_tests++;
                if (DONE !== 1'b1 || BUSY !== 1'b0 || WORD_READY !== 1'b0 || UNDERRUN !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_done got done=%b busy=%b rdy=%b und=%b want 1 0 0 0",
                             DONE, BUSY, WORD_READY, UNDERRUN);
                end
            end
            acc = WORD_VALID && WORD_READY;
            tick();
            if (acc) begin
                n_acc++;
                idx++;
                WORD_DATA = (idx < 3) ? words[(idx < 3) ? idx : 0] : 8'hEE;
                WORD_LAST = (idx == 2);
            end
        end
        WORD_VALID = 1'b0; WORD_LAST = 1'b0;
        n_tests++;
        if (n_acc != 3) begin
            n_fail++;
            $display("FAIL b2b_accepts got %0d want 3", n_acc);
        end
        tick();
    endtask

    task automatic test_underrun();
        logic [7:0] w;
        logic eb, eu;
        w = 8'h0F;
        start_frame(8'd0, w, 1'b0);
        for (int c = 0; c < 40; c++) begin
            eb = (c < 32) ? w[7 - c / 4] : 1'b0;
            eu = (c >= 32);
            n_tests++;
            if (EN !== 1'b1 || BIT_OUT !== eb || UNDERRUN !== eu || REQ_SAMPLE !== 1'b1 ||
                DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL und_run c=%0d got en=%b bit=%b und=%b req=%b done=%b want 1 %b %b 1 0",
                         c, EN, BIT_OUT, UNDERRUN, REQ_SAMPLE, DONE, eb, eu);
            end
            START = (c == 34);
            if (c == 34) DIV = 8'd5;
            tick();
        end
        START = 1'b0;
        n_tests++;
        if (DONE !== 1'b1 || UNDERRUN !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL und_done got done=%b und=%b busy=%b want 1 1 0", DONE, UNDERRUN, BUSY);
        end
        tick();
        n_tests++;
        if (UNDERRUN !== 1'b1) begin
            n_fail++;
            $display("FAIL und_sticky got und=%b want 1", UNDERRUN);
        end
        w = 8'h3C;
        START = 1'b1; DIV = 8'd0;
        tick();
        START = 1'b0;
        n_tests++;
        if (UNDERRUN !== 1'b0 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL und_clear got und=%b busy=%b want 0 1", UNDERRUN, BUSY);
        end
        WORD_DATA = w; WORD_LAST = 1'b1; WORD_VALID = 1'b1;
        tick();
        WORD_VALID = 1'b0; WORD_LAST = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            eb = (c < 32) ? w[7 - c / 4] : 1'b0;
            n_tests++;
            if (BIT_OUT !== eb || UNDERRUN !== 1'b0 || DONE !== (c == 40)) begin
                n_fail++;
                $display("FAIL und_next c=%0d got bit=%b und=%b done=%b want %b 0 %b",
                         c, BIT_OUT, UNDERRUN, DONE, eb, (c == 40));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        logic eb;
        start_frame(8'd0, 8'hA5, 1'b1);
        for (int c = 0; c < 13; c++) tick();
        RST = 1'b1;
        #1;
        n_tests++;
        if ({WORD_READY, REQ_SAMPLE, EN, BIT_OUT, BUSY, DONE, UNDERRUN} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_async got rdy/req/en/bit/busy/done/und=%b want 0000000",
                     {WORD_READY, REQ_SAMPLE, EN, BIT_OUT, BUSY, DONE, UNDERRUN});
        end
        tick(); tick();
        RST = 1'b0;
        for (int c = 0; c < 45; c++) begin
            n_tests++;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || EN !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_quiet c=%0d got done=%b busy=%b en=%b want 0 0 0",
                         c, DONE, BUSY, EN);
            end
            tick();
        end
        w = 8'h5A;
        start_frame(8'd0, w, 1'b1);
        for (int c = 0; c <= 40; c++) begin
            eb = (c < 32) ? w[7 - c / 4] : 1'b0;
            n_tests++;
            if (BIT_OUT !== eb || EN !== (c < 40) || DONE !== (c == 40)) begin
                n_fail++;
                $display("FAIL rst_restart c=%0d got bit=%b en=%b done=%b want %b %b %b",
                         c, BIT_OUT, EN, DONE, eb, (c < 40), (c == 40));
            end
            tick();
        end
    endtask

    task automatic test_ignored_start();
        logic [7:0] w;
        logic eb, er;
        w = 8'hC6;
        start_frame(8'd1, w, 1'b1);
        for (int c = 0; c < 80; c++) begin
            eb = (c < 64) ? w[7 - c / 8] : 1'b0;
            er = ((c % 2) == 1);
            n_tests++;
            if (BIT_OUT !== eb || REQ_SAMPLE !== er || EN !== 1'b1 || BUSY !== 1'b1 ||
                DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL ign_run c=%0d got bit=%b req=%b en=%b busy=%b done=%b want %b %b 1 1 0",
                         c, BIT_OUT, REQ_SAMPLE, EN, BUSY, DONE, eb, er);
            end
            START = (c == 10);
            if (c == 10) DIV = 8'd0;
            tick();
        end
        START = 1'b0;
        n_tests++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_done got done=%b busy=%b want 1 0", DONE, BUSY);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (BUSY !== 1'b0 || EN !== 1'b0 || DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL ign_after c=%0d got busy=%b en=%b done=%b want 0 0 0",
                         c, BUSY, EN, DONE);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_divider();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        test_ignored_start();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
